// File: rtl/uart_tx_framer.sv
// UART transmit framer: serializes one byte per accepted request as start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits. Line idles high and is driven from a register.
//
// state  | meaning
// IDLE   | line high, waiting for send_sig
// START  | start bit (low) for one bit period
// DATA   | data bits D0..D7, one bit period each
// PARITY | parity bit (only when PARITY_EN)
// STOP   | line high for STOP_BITS bit periods
module uart_tx_framer #(
    parameter int CLKS_PER_BAUD = 10416,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk100mhz,
    input  logic       cpu_resetn,
    input  logic       send_sig,
    input  logic [7:0] send_data,
    output logic       uart_rxd_out,
    output logic       busy_sending,
    output logic       send_done
);

    localparam int CW = 20;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift_reg, shift_nxt;
    logic            parity_bit, parity_nxt;
    logic            stop_cnt, stop_cnt_nxt;
    logic            tx_q, tx_nxt;
    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;
    logic            baud_end;

    assign baud_end = (baud_cnt == CW'(CLKS_PER_BAUD - 1));

    always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            stop_cnt   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_nxt;
            parity_bit <= parity_nxt;
            stop_cnt   <= stop_cnt_nxt;
            tx_q       <= tx_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_nxt     = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        parity_nxt   = parity_bit;
        stop_cnt_nxt = stop_cnt;
        tx_nxt       = tx_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;

        if (state != S_IDLE) begin
            baud_nxt = baud_end ? '0 : baud_cnt + CW'(1);
        end

        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (send_sig) begin
                    shift_nxt  = send_data;
                    parity_nxt = (^send_data) ^ (PARITY_ODD != 0);
                    tx_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                    baud_nxt   = '0;
                    state_nxt  = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    tx_nxt      = shift_reg[0];
                    bit_idx_nxt = '0;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    // shift register always presents the current bit at [0]
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        if (PARITY_EN != 0) begin
                            tx_nxt    = parity_bit;
                            state_nxt = S_PARITY;
                        end else begin
                            tx_nxt       = 1'b1;
                            stop_cnt_nxt = 1'b0;
                            state_nxt    = S_STOP;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign uart_rxd_out = tx_q;
    assign busy_sending = busy_q;
    assign send_done    = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: an 8N1 instance and an even-parity/2-stop instance,
// both at 16 clocks per bit, sharing clock, reset and request inputs.
module tb_uart_tx_framer;

    logic       clk100mhz = 1'b0;
    logic       cpu_resetn = 1'b1;
    logic       send_sig = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk100mhz = ~clk100mhz;

    uart_tx_framer #(.CLKS_PER_BAUD(16)) dut (
        .clk100mhz(clk100mhz), .cpu_resetn(cpu_resetn), .send_sig(send_sig), .send_data(send_data),
        .uart_rxd_out(tx_a), .busy_sending(busy_a), .send_done(done_a)
    );

    uart_tx_framer #(.CLKS_PER_BAUD(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
        .clk100mhz(clk100mhz), .cpu_resetn(cpu_resetn), .send_sig(send_sig), .send_data(send_data),
        .uart_rxd_out(tx_b), .busy_sending(busy_b), .send_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle request; returns at the first falling edge after the accepting edge.
    task automatic request(input logic [7:0] d);
        @(negedge clk100mhz);
        send_sig  = 1'b1;
        send_data = d;
        @(negedge clk100mhz);
        send_sig  = 1'b0;
    endtask

    // Compares the line every cycle against a bit vector (LSB = start bit), 16 cycles per bit,
    // then 20 idle cycles. mid[i] is the line sampled in the middle of bit i.
    task automatic watch(input bit sel, input int ncyc, input logic [15:0] bits, input int poke,
                         output int line_err, output int busy_cyc, output int done_cnt,
                         output int done_at, output logic [15:0] mid);
        logic expv, line;
        line_err = 0; busy_cyc = 0; done_cnt = 0; done_at = 0; mid = '1;
        for (int k = 1; k <= ncyc + 20; k++) begin
            line = sel ? tx_b : tx_a;
            expv = (k <= ncyc) ? bits[(k - 1) / 16] : 1'b1;
            if (line !== expv) line_err++;
            if (k <= ncyc && (k % 16) == 8) mid[k / 16] = line;
            if ((sel ? busy_b : busy_a) === 1'b1) busy_cyc++;
            if ((sel ? done_b : done_a) === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k == poke) begin
                send_sig  = 1'b1;
                send_data = 8'hFF;
            end else if (k == poke + 1) begin
                send_sig = 1'b0;
            end
            @(negedge clk100mhz);
        end
    endtask

    int          line_err, busy_cyc, done_cnt, done_at;
    logic [15:0] mid;

    initial begin
        int          hi_err, busy_seen, done_seen;
        int          starts[$];
        logic [7:0]  bytes[$];
        int          fstart, rel;
        logic        prev, line;
        logic [7:0]  sh;

        #1 cpu_resetn = 1'b0;
        #1;
        check("rst_line", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_line_p", tx_b, 1'b1);
        repeat (2) @(negedge clk100mhz);
        cpu_resetn = 1'b1;

        hi_err = 0; busy_seen = 0; done_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk100mhz);
            if (tx_a !== 1'b1) hi_err++;
            if (busy_a !== 1'b0) busy_seen++;
            if (done_a !== 1'b0) done_seen++;
        end
        check("idle_line", hi_err, 0);
        check("idle_busy", busy_seen, 0);
        check("idle_done", done_seen, 0);

        // 0x55, 8N1
        request(8'h55);
        watch(1'b0, 160, {6'h3F, 10'b1_01010101_0}, 0, line_err, busy_cyc, done_cnt, done_at, mid);
        check("x55_line", line_err, 0);
        check("x55_busy", busy_cyc, 160);
        check("x55_done_cnt", done_cnt, 1);
        check("x55_done_at", done_at, 161);
        check("x55_byte", mid[8:1], 8'h55);
        repeat (60) @(negedge clk100mhz);

        // 0x07, even parity, 2 stop bits: parity bit 1
        request(8'h07);
        watch(1'b1, 192, {4'hF, 12'b11_1_00000111_0}, 0, line_err, busy_cyc, done_cnt, done_at, mid);
        check("par_line", line_err, 0);
        check("par_bit", mid[9], 1'b1);
        check("par_stop", mid[11:10], 2'b11);
        check("par_busy", busy_cyc, 192);
        check("par_done_cnt", done_cnt, 1);
        check("par_done_at", done_at, 193);
        repeat (30) @(negedge clk100mhz);

        // 0xA3 accepted, then a 0xFF request at cycle 50 is ignored
        request(8'hA3);
        watch(1'b0, 160, {6'h3F, 10'b1_10100011_0}, 50, line_err, busy_cyc, done_cnt, done_at, mid);
        check("busy_ign_line", line_err, 0);
        check("busy_ign_byte", mid[8:1], 8'hA3);
        check("busy_ign_done", done_cnt, 1);
        check("busy_ign_busy", busy_cyc, 160);
        repeat (60) @(negedge clk100mhz);

        // send_sig held high with 0x3C: decode frames from the line
        @(negedge clk100mhz);
        send_data = 8'h3C;
        send_sig  = 1'b1;
        prev = 1'b1; fstart = -1; sh = '0;
        for (int t = 0; t < 520; t++) begin
            @(negedge clk100mhz);
            line = tx_a;
            if (fstart < 0) begin
                if (prev && !line) begin
                    fstart = t;
                    starts.push_back(t);
                end
            end else begin
                rel = t - fstart;
                if (rel >= 24 && rel <= 136 && ((rel - 24) % 16) == 0) sh = {line, sh[7:1]};
                if (rel == 152) begin
                    bytes.push_back(line ? sh : 8'h00);
                    fstart = -1;
                end
            end
            prev = line;
        end
        send_sig = 1'b0;
        check("held_starts", starts.size() >= 3, 1'b1);
        check("held_bytes", bytes.size() >= 3, 1'b1);
        if (starts.size() >= 3) begin
            check("held_gap0", starts[1] - starts[0], 161);
            check("held_gap1", starts[2] - starts[1], 161);
        end
        if (bytes.size() >= 3) begin
            for (int i = 0; i < 3; i++) check($sformatf("held_byte%0d", i), bytes[i], 8'h3C);
        end
        repeat (220) @(negedge clk100mhz);

        // reset mid-frame at cycle 70 of a 0x00 frame
        request(8'h00);
        repeat (69) @(negedge clk100mhz);
        check("pre_rst_line", tx_a, 1'b0);
        check("pre_rst_busy", busy_a, 1'b1);
        #1 cpu_resetn = 1'b0;
        #1;
        check("async_rst_line", tx_a, 1'b1);
        check("async_rst_busy", busy_a, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk100mhz);
            if (done_a !== 1'b0) done_seen++;
        end
        cpu_resetn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk100mhz);
            if (done_a !== 1'b0) done_seen++;
        end
        check("rst_no_done", done_seen, 0);

        request(8'h81);
        watch(1'b0, 160, {6'h3F, 10'b1_10000001_0}, 0, line_err, busy_cyc, done_cnt, done_at, mid);
        check("post_rst_line", line_err, 0);
        check("post_rst_byte", mid[8:1], 8'h81);
        check("post_rst_busy", busy_cyc, 160);
        check("post_rst_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
